f_fetch_ctrl: RTL and testbench
===============================

# f_fetch_ctrl

Fetch-stage controller for the five-stage MIPS pipeline. It owns the PC register, drives the instruction memory address, and captures the returned word into the F/D pipeline register. It applies hazard stalls and branch/jump redirects with one delay slot. It halts fetch permanently when the PC leaves the instruction memory window or becomes misaligned. It sits between the instruction memory (combinational read, base 0x00003000) and the D stage.

## Interface
- PC_RESET, 32'h00003000, PC after reset; also the base of the instruction memory window
- IM_WORDS, 1024, window size in words; valid PCs are PC_RESET to PC_RESET + 4*IM_WORDS - 4
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  from the hazard unit; holds the PC and the F/D register
- redirect_en  in  1  from D; a branch is taken or a jump is in D
- redirect_pc  in  32  target of the redirect
- im_addr  out  32  to the instruction memory; equals the current PC
- im_data  in  32  instruction word, valid in the same cycle
- D_instr  out  32  F/D register: instruction
- D_pc  out  32  F/D register: PC of D_instr
- D_valid  out  1  F/D register: D_instr is a real fetched instruction
- fetch_fault  out  1  sticky; fetch has stopped on a bad PC
- fetch_count  out  32  number of instructions delivered to D, saturating

## Operation
- States: RUN and FAULT. Reset enters RUN. FAULT is left only by reset.
- pc_bad is combinational. It is 1 when PC[1:0] != 0, when PC < PC_RESET, or when PC > PC_RESET + 4*IM_WORDS - 4. Do the comparison in 33-bit arithmetic so the window top cannot wrap.
- RUN, stall=1:
  - PC, D_instr, D_pc, D_valid and fetch_count hold.
  - redirect_en is ignored. The stalled branch in D reasserts it.
  - pc_bad is not acted on.
- RUN, stall=0, pc_bad=1:
  - Go to FAULT and set fetch_fault to 1.
  - D_valid goes to 0, D_instr to 0 (nop), D_pc to PC.
  - PC holds.
  - redirect_en is ignored.
- RUN, stall=0, pc_bad=0:
  - D_instr gets im_data, D_pc gets PC, D_valid gets 1.
  - fetch_count increments, saturating at 0xFFFFFFFF.
  - PC gets redirect_pc if redirect_en is 1, otherwise PC+4.
  - Delay slot: the word fetched in the redirect cycle is always delivered to D and is never squashed.
- FAULT:
  - PC holds; D_valid stays 0; D_instr stays 0.
  - stall and redirect_en are ignored.
  - fetch_count holds.
- im_addr is always equal to PC, including in FAULT.

## Timing
- Reset values:
  - PC = PC_RESET, so im_addr = 0x00003000.
  - D_instr = 0, D_pc = 0, D_valid = 0.
  - fetch_fault = 0, fetch_count = 0.
  - State = RUN.
- Reset has priority over every other input, including in FAULT and mid-stall.
- Latency: the word at PC reaches D_instr one clock after PC is presented. There is no bubble on sequential fetch.
- Redirect: redirect_pc appears on im_addr in the cycle after redirect_en is sampled with stall=0. The delay-slot word reaches D in that same cycle.
- A bad redirect target is accepted into PC. The fault is raised one cycle later, when that PC is evaluated.
- Running off the end:
  - The last valid word (PC_RESET + 4*IM_WORDS - 4) is delivered normally.
  - The next cycle evaluates PC_RESET + 4*IM_WORDS, so fetch_fault rises on the following edge.
- fetch_fault and D_valid are registered outputs. There is no combinational path from stall or redirect_en to any output except through PC into im_addr.

## Test plan
- Reset then linear fetch: hold reset 2 cycles and release with stall=0 and redirect_en=0.
  - im_addr steps 0x3000, 0x3004, 0x3008.
  - D_pc lags by one cycle, D_valid=1 from the first edge after release.
  - fetch_count=3 after 3 edges.
- Stall: assert stall for 2 cycles at PC=0x3008.
  - im_addr stays 0x3008.
  - D_pc stays 0x3004 and fetch_count is unchanged.
  - On release, D_pc becomes 0x3008.
- Redirect with delay slot: at PC=0x3010, assert redirect_en with redirect_pc=0x3100 and stall=0.
  - The next D_pc is 0x3010 (delay slot, D_valid=1).
  - im_addr is 0x3100; one cycle later D_pc is 0x3100.
- Stall and redirect in the same cycle at PC=0x3010: PC stays 0x3010 and the redirect is dropped. Reasserting with stall=0 on the next cycle performs the redirect.
- Faults:
  - Redirect to 0x3102: the delay slot is delivered, then fetch_fault=1, D_valid=0 and im_addr frozen at 0x3102. stall and redirect have no effect afterwards.
  - With IM_WORDS=4, sequential fetch faults when the PC reaches 0x3010.
- Reset mid-fault: pulse reset while in FAULT. All outputs return to their reset values and fetch resumes from 0x3000.

Source files
------------

// File: rtl/f_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, drives instruction memory, fills the F/D register.
// Handles stalls, delay-slot redirects, and a sticky halt on an out-of-window or misaligned PC.
module f_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic        D_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // 33-bit bounds so a window ending at the top of the address space cannot wrap
  localparam logic [32:0] WinLo = {1'b0, PC_RESET};
  localparam logic [32:0] WinHi = {1'b0, PC_RESET} + 33'(IM_WORDS) * 33'd4 - 33'd4;

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] count_q, count_d;
  logic        pc_bad;

  assign pc_bad = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} < WinLo) || ({1'b0, pc_q} > WinHi);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      pc_q      <= PC_RESET;
      d_instr_q <= 32'h0;
      d_pc_q    <= 32'h0;
      d_valid_q <= 1'b0;
      count_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    count_d   = count_q;

    unique case (state_q)
      StRun: begin
        // A stalled cycle drops redirect_en; the branch held in D reasserts it.
        if (!stall) begin
          if (pc_bad) begin
            state_d   = StFault;
            d_instr_d = 32'h0;
            d_pc_d    = pc_q;
            d_valid_d = 1'b0;
          end else begin
            d_instr_d = im_data;
            d_pc_d    = pc_q;
            d_valid_d = 1'b1;
            count_d   = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
            pc_d      = redirect_en ? redirect_pc : pc_q + 32'd4;
          end
        end
      end
      StFault: begin
        d_instr_d = 32'h0;
        d_valid_d = 1'b0;
      end
      default: state_d = StFault;
    endcase
  end

  assign im_addr     = pc_q;
  assign D_instr     = d_instr_q;
  assign D_pc        = d_pc_q;
  assign D_valid     = d_valid_q;
  assign fetch_fault = (state_q == StFault);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Scoreboard bench for f_fetch_ctrl: a full-size and a 4-word-window instance share random
// stimulus; a reference model predicts each edge and a monitor compares after it.
module tb_f_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dpc;
    logic        valid;
    logic        fault;
    logic [31:0] cnt;
  } model_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] im_addr0, im_data0, d_instr0, d_pc0, cnt0;
  logic        d_valid0, fault0;
  logic [31:0] im_addr1, im_data1, d_instr1, d_pc1, cnt1;
  logic        d_valid1, fault1;

  int compared = 0;
  int mismatched = 0;
  model_t m0, m1;
  model_t q0[$];
  model_t q1[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign im_data0 = mem_word(im_addr0);
  assign im_data1 = mem_word(im_addr1);

  f_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .im_addr(im_addr0), .im_data(im_data0), .D_instr(d_instr0),
    .D_pc(d_pc0), .D_valid(d_valid0), .fetch_fault(fault0), .fetch_count(cnt0)
  );

  f_fetch_ctrl #(.IM_WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .im_addr(im_addr1), .im_data(im_data1), .D_instr(d_instr1),
    .D_pc(d_pc1), .D_valid(d_valid1), .fetch_fault(fault1), .fetch_count(cnt1)
  );

  // Reference behaviour of one clock edge, straight from the fetch rules.
  function automatic model_t step(input model_t m, input bit rst, input bit st, input bit re,
                                  input logic [31:0] rpc, input int unsigned words);
    model_t n = m;
    bit bad;
    if (rst) begin
      n = '{pc: 32'h3000, instr: 32'h0, dpc: 32'h0, valid: 1'b0, fault: 1'b0, cnt: 32'h0};
      return n;
    end
    if (m.fault || st) return n;
    bad = (m.pc % 4 != 0) || (64'(m.pc) < 64'h3000) ||
          (64'(m.pc) > 64'h3000 + 64'(words) * 64'd4 - 64'd4);
    if (bad) begin
      n.fault = 1'b1;
      n.valid = 1'b0;
      n.instr = 32'h0;
      n.dpc   = m.pc;
    end else begin
      n.instr = mem_word(m.pc);
      n.dpc   = m.pc;
      n.valid = 1'b1;
      n.cnt   = (m.cnt == 32'hFFFF_FFFF) ? m.cnt : m.cnt + 32'd1;
      n.pc    = re ? rpc : m.pc + 32'd4;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 = step(m0, reset, stall, redirect_en, redirect_pc, 1024);
    m1 = step(m1, reset, stall, redirect_en, redirect_pc, 4);
    q0.push_back(m0);
    q1.push_back(m1);
  end

  task automatic cmp(input string nm, input model_t e, input model_t a);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s t=%0t got pc=%h instr=%h dpc=%h v=%b f=%b cnt=%0d exp pc=%h instr=%h dpc=%h v=%b f=%b cnt=%0d",
               nm, $time, a.pc, a.instr, a.dpc, a.valid, a.fault, a.cnt,
               e.pc, e.instr, e.dpc, e.valid, e.fault, e.cnt);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_underflow t=%0t got sizes %0d/%0d exp nonzero",
               $time, q0.size(), q1.size());
    end else begin
      cmp("dut_full", q0.pop_front(),
          '{pc: im_addr0, instr: d_instr0, dpc: d_pc0, valid: d_valid0, fault: fault0, cnt: cnt0});
      cmp("dut_w4", q1.pop_front(),
          '{pc: im_addr1, instr: d_instr1, dpc: d_pc1, valid: d_valid1, fault: fault1, cnt: cnt1});
    end
  end

  task automatic cyc(input bit r, input bit s, input bit re, input logic [31:0] rpc);
    reset = r;
    stall = s;
    redirect_en = re;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0: return 32'h3000 + 32'd4 * $urandom_range(0, 1023);
      1: return 32'h3000 + 32'd4 * $urandom_range(0, 5);
      2: return 32'h3000 + 32'd4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
      3: return 32'h3FFC - 32'd4 * $urandom_range(0, 2);
      4: return 32'h4000;
      default: return 32'h2FFC;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);                  // D gets 0x3000
    cyc(0, 0, 0, 0);                  // PC now 0x3008
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);                  // PC now 0x3010
    cyc(0, 1, 1, 32'h3100);           // dropped by stall
    cyc(0, 0, 1, 32'h3100);           // delay slot 0x3010 delivered
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h3102);           // bad target accepted
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h3000);
    cyc(0, 0, 1, 32'h3000);
    cyc(1, 1, 1, 32'h3100);           // reset mid-fault
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h3FF8);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);   // run off the top of the window
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0), rand_target());
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain got sizes %0d/%0d exp 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
